// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD converter (double dabble); done pulses WIDTH edges after accept, start ignored while busy.
// Optional overflow flag via macro BCD_CONV_OVF_EN.
module bcd_conv_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_CONV_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;

  logic [BW-1:0]   acc_adj;
  logic [BW-1:0]   acc_shift;
  logic            top_carry;
  logic [3:0]      digit;

  always_comb begin
    acc_adj = acc_q;
    digit   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = acc_q[4*i +: 4];
      acc_adj[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
  end

  // Bit shifted out of the top digit is worth exactly 10^DIGITS; dropping it truncates.
  assign {top_carry, acc_shift} = {acc_adj, sr_q[WIDTH-1]};

`ifdef BCD_CONV_OVF_EN
  logic ovf_acc_q, ovf_acc_d;
  logic ovf_q, ovf_d;
`else
  logic top_carry_unused;
  assign top_carry_unused = top_carry;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
`ifdef BCD_CONV_OVF_EN
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONV;
          sr_d    = din;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
`ifdef BCD_CONV_OVF_EN
          ovf_acc_d = 1'b0;
`endif
        end
      end
      S_CONV: begin
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        acc_d = acc_shift;
        cnt_d = cnt_q - 1'b1;
`ifdef BCD_CONV_OVF_EN
        ovf_acc_d = ovf_acc_q | top_carry;
`endif
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          bcd_d   = acc_shift;
`ifdef BCD_CONV_OVF_EN
          ovf_d   = ovf_acc_q | top_carry;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
`ifdef BCD_CONV_OVF_EN
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
`ifdef BCD_CONV_OVF_EN
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_CONV) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign bcd   = bcd_q;
`ifdef BCD_CONV_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
